// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M divide unit: operation codes, FSM states and
// the decoder constants that select this unit.
package div_unit_pkg;

  // Matches funct3[1:0] of the RV32M divide/remainder instructions.
  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] Funct7MulDiv = 7'b0000001;
  localparam logic [2:0] Funct3Div    = 3'b100;
  localparam logic [2:0] Funct3Divu   = 3'b101;
  localparam logic [2:0] Funct3Rem    = 3'b110;
  localparam logic [2:0] Funct3Remu   = 3'b111;

  function automatic logic op_is_signed(div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_udiv_iter.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step.
module udiv_iter #(
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = $clog2(Width)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic [Width-1:0] quot_next,
  output logic [Width-1:0] rem_next,
  output logic             last
);

  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quot_q, quot_d;
  logic [Width-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width:0]   shifted, diff;

  // quot_q starts as the dividend; its MSB feeds the remainder while quotient
  // bits shift in from the bottom.
  always_comb begin
    shifted   = {rem_q, quot_q[Width-1]};
    diff      = shifted - {1'b0, dvsr_q};
    rem_next  = diff[Width] ? shifted[Width-1:0] : diff[Width-1:0];
    quot_next = {quot_q[Width-2:0], ~diff[Width]};
    last      = (cnt_q == CntW'(Width - 1));
  end

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvsr_d = divisor;
      cnt_d  = '0;
    end else if (step) begin
      rem_d  = rem_next;
      quot_d = quot_next;
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M divide/remainder unit: sign handling, special cases and handshake FSM
// around the unsigned iterative core.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = '1;

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  div_op_e         op_in;
  logic            signed_in, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic [XLEN-1:0] quot_next, rem_next, quot_fix, rem_fix, final_res;
  logic            load, step, last;

  udiv_iter #(
    .Width(XLEN)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quot_next(quot_next),
    .rem_next (rem_next),
    .last     (last)
  );

  always_comb begin
    op_in     = div_op_e'(op);
    signed_in = op_is_signed(op_in);
    a_neg     = signed_in & dividend[XLEN-1];
    b_neg     = signed_in & divisor[XLEN-1];
    a_abs     = a_neg ? -dividend : dividend;
    b_abs     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    overflow  = signed_in & (dividend == MinInt) & (divisor == AllOnes);
    if (div_zero) begin
      special_res = op_is_rem(op_in) ? dividend : AllOnes;
    end else begin
      special_res = op_is_rem(op_in) ? '0 : dividend;
    end
    // Negating a zero magnitude gives zero, so no negative-zero handling needed.
    quot_fix  = qneg_q ? -quot_next : quot_next;
    rem_fix   = rneg_q ? -rem_next : rem_next;
    final_res = op_is_rem(op_q) ? rem_fix : quot_fix;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rd_d     = rd_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !kill) begin
          op_d = op_in;
          rd_d = rd_in;
          if (div_zero || overflow) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            load    = 1'b1;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
          if (last) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = ~ready;
  // A kill landing in the DONE cycle suppresses that operation's valid.
  assign valid  = (state_q == StDone) & ~kill;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized ops
// against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [4:0]  rd_in;
  logic        ready, busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  div_unit #(
    .XLEN(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .rd_in   (rd_in),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .result  (result),
    .rd_out  (rd_out)
  );

  always #5 clk = ~clk;

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to valid; poke pulses start while busy.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, b, input logic [4:0] r,
                       input bit poke, input string tag);
    logic [31:0] exp;
    int exp_lat, lat, extra;
    bit busy_ok;
    exp     = model(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : 33;
    @(negedge clk);
    chk({tag, ":ready"}, 32'(ready), 32'd1);
    op = o; dividend = a; divisor = b; rd_in = r; start = 1'b1;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      @(negedge clk);
      start = poke && (i == 5);
      if (start) begin
        op = OpDivu; dividend = $urandom; divisor = 32'd1; rd_in = 5'd31;
      end
      if (valid) lat = i;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":result"}, result, exp);
    chk({tag, ":rd_out"}, 32'(rd_out), 32'(r));
    chk({tag, ":busy"}, 32'(busy_ok), 32'd1);
    extra = 0;
    for (int i = 0; i < (poke ? 40 : 1); i++) begin
      @(negedge clk);
      if (valid) extra++;
    end
    chk({tag, ":single_valid"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset:ready", 32'(ready), 32'd1);
    chk("reset:valid", 32'(valid), 32'd0);
    chk("reset:result", result, 32'd0);
    chk("reset:rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;

    do_op(OpDivu, 32'd100, 32'd7, 5'd17, 1'b0, "divu_100_7");
    do_op(OpRemu, 32'd100, 32'd7, 5'd4, 1'b0, "remu_100_7");
    do_op(OpDiv, -32'sd7, 32'd2, 5'd5, 1'b0, "div_m7_2");
    do_op(OpRem, -32'sd7, 32'd2, 5'd6, 1'b0, "rem_m7_2");
    do_op(OpDiv, 32'd7, -32'sd2, 5'd7, 1'b0, "div_7_m2");
    do_op(OpRem, 32'd7, -32'sd2, 5'd8, 1'b0, "rem_7_m2");
    do_op(OpDivu, 32'h1234, 32'd0, 5'd9, 1'b0, "divu_by0");
    do_op(OpRem, 32'h1234, 32'd0, 5'd10, 1'b0, "rem_by0");
    do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, "div_ovf");
    do_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, "rem_ovf");
    do_op(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0, "divu_ovf_ops");
    do_op(OpDiv, 32'd0, -32'sd5, 5'd14, 1'b0, "div_negzero");
    do_op(OpRem, -32'sd10, 32'd5, 5'd15, 1'b0, "rem_zero_neg");
    do_op(OpDivu, 32'd1000, 32'd9, 5'd16, 1'b1, "busy_poke");

    // Kill mid-CALC: back to idle next cycle, no valid ever.
    @(negedge clk);
    op = OpDivu; dividend = 32'd1000; divisor = 32'd7; rd_in = 5'd3; start = 1'b1;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) seen++;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill:ready", 32'(ready), 32'd1);
    chk("kill:valid", 32'(valid), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("kill:no_valid", 32'(seen), 32'd0);
    do_op(OpDivu, 32'd9, 32'd3, 5'd2, 1'b0, "after_kill");

    // kill together with start in IDLE wins.
    @(negedge clk);
    op = OpDivu; dividend = 32'd50; divisor = 32'd5; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill_start:ready", 32'(ready), 32'd1);

    // Reset mid-CALC.
    op = OpDiv; dividend = 32'd12345; divisor = 32'd17; rd_in = 5'd21; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset:ready", 32'(ready), 32'd1);
    chk("midreset:valid", 32'(valid), 32'd0);
    chk("midreset:result", result, 32'd0);
    chk("midreset:rd_out", 32'(rd_out), 32'd0);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'd0;
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       begin ra = 32'($urandom_range(0, 100)); rb = $urandom; end
        default: rb = -32'($urandom_range(1, 300));
      endcase
      do_op(ro, ra, rb, 5'($urandom_range(0, 31)), 1'b0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
